// File: rtl/imem_arbiter.sv
// Two-master instruction-memory arbiter: round-robin selection held until grant, plus an
// outstanding-ID FIFO that steers each rvalid/rdata back to the master that issued it.
module imem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  err_o
);

    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {StArb, StHold} state_e;

    state_e                     state_q, state_d;
    logic                       sel_q, sel_d;
    logic                       last_q, last_d;
    logic                       err_q, err_d;
    logic [MAX_OUTSTANDING-1:0] id_q;
    logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]            count_q;

    logic full, empty, push, pop, cur_sel, hold_req, head_id;

    // Pointers wrap at MAX_OUTSTANDING, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        mem_req_o = 1'b0;
        cur_sel   = 1'b0;
        push      = 1'b0;
        hold_req  = sel_q ? m1_req_i : m0_req_i;
        unique case (state_q)
            StArb: begin
                if (!full && (m0_req_i || m1_req_i)) begin
                    cur_sel   = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
                    mem_req_o = 1'b1;
                    if (mem_gnt_i) begin
                        push   = 1'b1;
                        last_d = cur_sel;
                    end else begin
                        sel_d   = cur_sel;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                cur_sel   = sel_q;
                mem_req_o = hold_req;
                if (hold_req && mem_gnt_i) begin
                    push    = 1'b1;
                    last_d  = sel_q;
                    state_d = StArb;
                end else if (!hold_req) begin
                    // Requester withdrew without a grant: release the lock, keep priority.
                    state_d = StArb;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_comb begin
        mem_addr_o = '0;
        if (mem_req_o) begin
            mem_addr_o = cur_sel ? m1_addr_i : m0_addr_i;
        end
    end

    assign m0_gnt_o = mem_gnt_i & mem_req_o & ~cur_sel;
    assign m1_gnt_o = mem_gnt_i & mem_req_o & cur_sel;

    assign pop     = mem_rvalid_i & ~empty;
    assign head_id = id_q[rd_ptr_q];

    assign m0_rvalid_o = pop & ~head_id;
    assign m1_rvalid_o = pop & head_id;
    assign m0_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
    assign m1_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;

    assign err_d = err_q | (mem_rvalid_i & empty);
    assign err_o = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StArb;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            err_q   <= err_d;
            if (push) begin
                id_q[wr_ptr_q] <= cur_sel;
                wr_ptr_q       <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_imem_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          r0, r1, gnt, rv;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] rd;

    logic          m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          mem_req_o, err_o;
    logic [AW-1:0] mem_addr_o;

    imem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_i     (r0),
        .m0_addr_i    (a0),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_rdata_o   (m0_rdata_o),
        .m1_req_i     (r1),
        .m1_addr_i    (a1),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_rdata_o   (m1_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (gnt),
        .mem_rvalid_i (rv),
        .mem_rdata_i  (rd),
        .err_o        (err_o)
    );

    typedef struct packed {
        logic          g0, g1, rv0, rv1, mreq;
        logic [AW-1:0] maddr;
        logic          err;
    } exp_t;

    typedef struct {
        logic          r0, r1, gnt, rv;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] rd;
        exp_t          e;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: outstanding IDs as a queue, the locked master (-1 = arbitrating).
    int q[$];
    int lock;
    int last;
    bit merr;
    int m_sel;
    bit m_mreq;
    exp_t last_e;

    task automatic model_reset();
        q.delete();
        lock = -1;
        last = 1;
        merr = 1'b0;
    endtask

    task automatic model_eval(output exp_t e);
        e      = '0;
        m_sel  = 0;
        m_mreq = 1'b0;
        if (lock >= 0) begin
            m_sel  = lock;
            m_mreq = (lock == 0) ? r0 : r1;
        end else if (q.size() < MAXO && (r0 || r1)) begin
            m_sel  = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
            m_mreq = 1'b1;
        end
        e.mreq  = m_mreq;
        e.maddr = m_mreq ? (m_sel == 0 ? a0 : a1) : '0;
        e.g0    = gnt && m_mreq && m_sel == 0;
        e.g1    = gnt && m_mreq && m_sel == 1;
        if (rv && q.size() > 0) begin
            e.rv0 = (q[0] == 0);
            e.rv1 = (q[0] == 1);
        end
        e.err = merr;
    endtask

    task automatic model_commit();
        if (rv) begin
            if (q.size() > 0) void'(q.pop_front());
            else merr = 1'b1;
        end
        if (m_mreq && gnt) begin
            q.push_back(m_sel);
            last = m_sel;
            lock = -1;
        end else if (lock >= 0 && !m_mreq) begin
            lock = -1;
        end else if (lock < 0 && m_mreq) begin
            lock = m_sel;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        logic [DW-1:0] erd;
        erd = rv ? rd : '0;
        chk({tag, ".m0_gnt"}, m0_gnt_o, e.g0);
        chk({tag, ".m1_gnt"}, m1_gnt_o, e.g1);
        chk({tag, ".m0_rvalid"}, m0_rvalid_o, e.rv0);
        chk({tag, ".m1_rvalid"}, m1_rvalid_o, e.rv1);
        chk({tag, ".mem_req"}, mem_req_o, e.mreq);
        chk({tag, ".mem_addr"}, mem_addr_o, e.maddr);
        chk({tag, ".err"}, err_o, e.err);
        chk({tag, ".m0_rdata"}, m0_rdata_o, erd);
        chk({tag, ".m1_rdata"}, m1_rdata_o, erd);
    endtask

    task automatic drive(input logic ir0, input logic [AW-1:0] ia0, input logic ir1,
                         input logic [AW-1:0] ia1, input logic ignt, input logic irv,
                         input logic [DW-1:0] ird);
        r0 = ir0; a0 = ia0; r1 = ir1; a1 = ia1; gnt = ignt; rv = irv; rd = ird;
    endtask

    // One cycle: inputs already driven after a falling edge; check, then clock the model.
    task automatic cyc(input string tag);
        exp_t e;
        #1;
        model_eval(e);
        compare(tag, e);
        last_e = e;
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic ir0, input logic [AW-1:0] ia0, input logic ir1,
                                input logic [AW-1:0] ia1, input logic ignt, input logic irv,
                                input logic [DW-1:0] ird, input logic g0, input logic g1,
                                input logic v0, input logic v1, input logic mreq,
                                input logic [AW-1:0] maddr);
        vec_t v;
        v.r0 = ir0; v.a0 = ia0; v.r1 = ir1; v.a1 = ia1;
        v.gnt = ignt; v.rv = irv; v.rd = ird;
        v.e.g0 = g0; v.e.g1 = g1; v.e.rv0 = v0; v.e.rv1 = v1;
        v.e.mreq = mreq; v.e.maddr = maddr; v.e.err = 1'b0;
        return v;
    endfunction

    localparam logic [DW-1:0] D0 = 32'h1000_0113;
    localparam logic [DW-1:0] D1 = 32'hF81F_F06F;

    initial begin
        vec_t vecs[$];
        exp_t e;

        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        compare("reset", '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: m0 first after reset, then alternating; rdata routed by ID.
        vecs.push_back(mk(1, 8'h00, 1, 8'h80, 1, 0, 0,  1, 0, 0, 0, 1, 8'h00));
        vecs.push_back(mk(1, 8'h00, 1, 8'h80, 1, 1, D0, 0, 1, 1, 0, 1, 8'h80));
        vecs.push_back(mk(1, 8'h00, 1, 8'h80, 1, 1, D1, 1, 0, 0, 1, 1, 8'h00));
        vecs.push_back(mk(1, 8'h00, 1, 8'h80, 1, 1, D0, 0, 1, 1, 0, 1, 8'h80));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, D1, 0, 0, 0, 1, 0, 8'h00));
        // Single master, grant after 2 waits, rvalid 2 cycles after grant.
        vecs.push_back(mk(1, 8'h04, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 8'h04));
        vecs.push_back(mk(1, 8'h04, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 8'h04));
        vecs.push_back(mk(1, 8'h04, 0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 1, 8'h04));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 32'h0010_0093, 0, 0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        // Hold lock: m1 arrives while m0 waits; address stays on m0 until its grant.
        vecs.push_back(mk(1, 8'h10, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 8'h10));
        vecs.push_back(mk(1, 8'h10, 1, 8'h90, 0, 0, 0, 0, 0, 0, 0, 1, 8'h10));
        vecs.push_back(mk(1, 8'h10, 1, 8'h90, 0, 0, 0, 0, 0, 0, 0, 1, 8'h10));
        vecs.push_back(mk(1, 8'h10, 1, 8'h90, 1, 0, 0, 1, 0, 0, 0, 1, 8'h10));
        vecs.push_back(mk(0, 8'h00, 1, 8'h90, 1, 0, 0, 0, 1, 0, 0, 1, 8'h90));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 32'hAAAA_0001, 0, 0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 32'hBBBB_0002, 0, 0, 0, 1, 0, 8'h00));

        foreach (vecs[i]) begin
            drive(vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1, vecs[i].gnt, vecs[i].rv,
                  vecs[i].rd);
            #1;
            compare($sformatf("vec%0d", i), vecs[i].e);
            model_eval(e);
            @(posedge clk);
            model_commit();
            @(negedge clk);
        end

        // FIFO full: two immediate grants with no rvalid block further requests.
        drive(1, 8'h20, 0, 0, 1, 0, 0);
        cyc("full_g1");
        cyc("full_g2");
        #1 chk("full_blocks_req", mem_req_o, 0);
        cyc("full_wait");
        drive(1, 8'h20, 0, 0, 1, 1, 32'h1111_0001);
        #1 chk("full_pop_req_still_low", mem_req_o, 0);
        chk("full_pop_rvalid", m0_rvalid_o, 1);
        cyc("full_pop");
        drive(1, 8'h20, 0, 0, 1, 1, 32'h1111_0002);
        #1 chk("push_pop_req", mem_req_o, 1);
        cyc("push_pop");
        drive(1, 8'h20, 0, 0, 1, 0, 0);
        cyc("refill");
        #1 chk("refull_blocks_req", mem_req_o, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h1111_0003);
        cyc("drain1");
        cyc("drain2");

        // Spurious rvalid with nothing outstanding sets a sticky error.
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        cyc("spurious");
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("err_sticky%0d", i), err_o, 1);
            cyc("idle_err");
        end

        // Reset while holding with one transaction outstanding.
        drive(1, 8'h30, 0, 0, 1, 0, 0);
        cyc("pre_rst_grant");
        drive(1, 8'h34, 0, 0, 0, 0, 0);
        cyc("pre_rst_hold");
        #2;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_gnt", {m0_gnt_o, m1_gnt_o}, 0);
        chk("rst_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
        chk("rst_rdata", {m0_rdata_o, m1_rdata_o}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 32'h5555_AAAA);
        cyc("late_rvalid");
        drive(1, 8'h40, 1, 8'hC0, 1, 0, 0);
        #1 chk("late_err", err_o, 1);
        chk("post_rst_prio_m0", m0_gnt_o, 1);
        cyc("post_rst_arb");

        // Randomized traffic against the model.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        last_e = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (!(r0 && !last_e.g0 && $urandom_range(15) != 0)) begin
                r0 = 1'($urandom_range(1));
                a0 = AW'($urandom);
            end
            if (!(r1 && !last_e.g1 && $urandom_range(15) != 0)) begin
                r1 = 1'($urandom_range(1));
                a1 = AW'($urandom);
            end
            gnt = ($urandom_range(2) != 0);
            rv  = (q.size() > 0) && ($urandom_range(1) == 1);
            rd  = $urandom;
            cyc($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
